// File: rtl/position_sel.sv
// ============================================================================
// position_sel
//
// Cursor-driven mark placement for a BOARD_N x BOARD_N board (tic-tac-toe
// style). A row/column cursor is steered by single-cycle move requests. A
// commit places the mark of the player to move (X or O) at the cursor when
// that cell is free. Each commit produces a one-cycle accept or reject pulse
// on the following cycle. On accept, out_en also pulses the one-hot of the
// cell that was written.
//
// Parameters
//   BOARD_N      board side length (2..8)
//   CELLS, IDXW  derived cell count and cursor index width (not overridable)
//
// Ports
//   clk                   sole clock, rising edge
//   rst                   asynchronous, active-high reset
//   enable                gates moves, commits and cursor_oh
//   mv_up/down/left/right single-cycle cursor move requests
//   commit                place the current player's mark at the cursor
//   clear                 synchronous game restart (acts even when disabled)
//   cursor_idx            registered row-major cursor index
//   cursor_oh             one-hot of cursor_idx, zero while enable=0
//   out_en                one-cycle one-hot of the cell just written
//   occ_x, occ_o          registered occupancy per player
//   turn                  player to move (0=X, 1=O)
//   accept, reject        one-cycle commit result pulses
//   full                  every cell occupied
//
// Configuration
//   POSITION_SEL_WRAP_EN  when defined, the cursor wraps at the board edges.
//                         When undefined, a move past an edge is ignored.
// ============================================================================
module position_sel #(
    parameter  int BOARD_N = 3,
    localparam int CELLS   = BOARD_N * BOARD_N,
    localparam int IDXW    = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mv_up,
    input  logic             mv_down,
    input  logic             mv_left,
    input  logic             mv_right,
    input  logic             commit,
    input  logic             clear,
    output logic [IDXW-1:0]  cursor_idx,
    output logic [CELLS-1:0] cursor_oh,
    output logic [CELLS-1:0] out_en,
    output logic [CELLS-1:0] occ_x,
    output logic [CELLS-1:0] occ_o,
    output logic             turn,
    output logic             accept,
    output logic             reject,
    output logic             full
);

    localparam int            RW   = $clog2(BOARD_N);
    localparam logic [RW-1:0] LAST = RW'(BOARD_N - 1);

    logic [RW-1:0]    row_q, row_d;
    logic [RW-1:0]    col_q, col_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CELLS-1:0] occ_x_q, occ_x_d;
    logic [CELLS-1:0] occ_o_q, occ_o_d;
    logic             turn_q, turn_d;
    logic             accept_q, accept_d;
    logic             reject_q, reject_d;
    logic [CELLS-1:0] out_en_q, out_en_d;

    logic [CELLS-1:0] cell_oh;
    logic [CELLS-1:0] occ_all;
    logic             single_move;

    assign cell_oh     = CELLS'(1) << idx_q;
    assign occ_all     = occ_x_q | occ_o_q;
    assign full        = &occ_all;
    // Conflicting or combined move requests are ignored as a whole.
    assign single_move = $onehot({mv_up, mv_down, mv_left, mv_right});

    // The commit is judged against the pre-move cursor (idx_q). Any move in
    // the same cycle then updates row/col. Occupancy is registered, so a
    // commit on the next cycle already sees this cycle's mark.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        occ_x_d  = occ_x_q;
        occ_o_d  = occ_o_q;
        turn_d   = turn_q;
        accept_d = 1'b0;
        reject_d = 1'b0;
        out_en_d = '0;

        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            occ_x_d = '0;
            occ_o_d = '0;
            turn_d  = 1'b0;
        end else if (enable) begin
            if (commit) begin
                if (((occ_all & cell_oh) == '0) && !full) begin
                    if (turn_q) occ_o_d = occ_o_q | cell_oh;
                    else        occ_x_d = occ_x_q | cell_oh;
                    turn_d   = ~turn_q;
                    accept_d = 1'b1;
                    out_en_d = cell_oh;
                end else begin
                    reject_d = 1'b1;
                end
            end

            if (single_move) begin
                if (mv_up) begin
                    if (row_q != '0) row_d = row_q - RW'(1);
`ifdef POSITION_SEL_WRAP_EN
                    else             row_d = LAST;
`endif
                end
                if (mv_down) begin
                    if (row_q != LAST) row_d = row_q + RW'(1);
`ifdef POSITION_SEL_WRAP_EN
                    else               row_d = '0;
`endif
                end
                if (mv_left) begin
                    if (col_q != '0) col_d = col_q - RW'(1);
`ifdef POSITION_SEL_WRAP_EN
                    else             col_d = LAST;
`endif
                end
                if (mv_right) begin
                    if (col_q != LAST) col_d = col_q + RW'(1);
`ifdef POSITION_SEL_WRAP_EN
                    else               col_d = '0;
`endif
                end
            end
        end

        // Row and column never exceed BOARD_N-1, so the index stays below CELLS.
        idx_d = IDXW'(row_d) * IDXW'(BOARD_N) + IDXW'(col_d);
    end

    // State register. Reset also clears the result pulses, so a commit that
    // was in flight when reset arrived leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            idx_q    <= '0;
            occ_x_q  <= '0;
            occ_o_q  <= '0;
            turn_q   <= 1'b0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            out_en_q <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            idx_q    <= idx_d;
            occ_x_q  <= occ_x_d;
            occ_o_q  <= occ_o_d;
            turn_q   <= turn_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
            out_en_q <= out_en_d;
        end
    end

    assign cursor_idx = idx_q;
    assign cursor_oh  = enable ? cell_oh : '0;
    assign out_en     = out_en_q;
    assign occ_x      = occ_x_q;
    assign occ_o      = occ_o_q;
    assign turn       = turn_q;
    assign accept     = accept_q;
    assign reject     = reject_q;

endmodule

// File: doc/position_sel.md
POSITION_SEL -- requirements
Module: position_sel

Interface
REQ-001 SHALL have parameter BOARD_N, default 3, meaning board side length (board is BOARD_N x BOARD_N cells, legal range 2..8).
REQ-002 SHALL derive CELLS = BOARD_N*BOARD_N and IDXW = $clog2(CELLS) as localparams, not overridable.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  gates all commands and the cursor one-hot output.
REQ-006 SHALL have ports mv_up, mv_down, mv_left, mv_right  in  1 each  single-cycle cursor move requests.
REQ-007 SHALL have port commit  in  1  request to place current player's mark at the cursor.
REQ-008 SHALL have port clear  in  1  synchronous board/game restart.
REQ-009 SHALL have port cursor_idx  out  IDXW  registered row-major cursor index (row*BOARD_N+col).
REQ-010 SHALL have port cursor_oh  out  CELLS  one-hot of cursor_idx, all zeros when enable=0.
REQ-011 SHALL have port out_en  out  CELLS  one-cycle one-hot pulse of the cell just written.
REQ-012 SHALL have ports occ_x, occ_o  out  CELLS each  registered occupancy per player.
REQ-013 SHALL have port turn  out  1  player to move, 0=X, 1=O.
REQ-014 SHALL have ports accept, reject  out  1 each  one-cycle commit result pulses.
REQ-015 SHALL have port full  out  1  high when every cell is occupied (combinational from occ_x|occ_o).

Function
REQ-016 Commands (moves, commit) SHALL be sampled only on cycles with enable=1; clear SHALL act regardless of enable.
REQ-017 Cursor SHALL track row and column separately; mv_up/down change row by -1/+1, mv_left/right change column by -1/+1.
REQ-018 If more than one mv_* is high in a cycle, the cursor SHALL NOT move.
REQ-019 A legal commit (enable=1, commit=1, cell unoccupied in occ_x|occ_o, full=0) SHALL set the cell's bit in occ_x (turn=0) or occ_o (turn=1) and toggle turn at the same edge.
REQ-020 accept and out_en SHALL assert for exactly the cycle following a legal commit; out_en SHALL be the one-hot of the committed index.
REQ-021 An illegal commit (cell occupied or full=1) SHALL leave occ_x, occ_o, turn unchanged and pulse reject for the following cycle.
REQ-022 accept and reject SHALL never be high together; with no commit both SHALL be low and out_en zero.
REQ-023 Commit and a move in the same cycle SHALL commit at the pre-move cursor and then apply the move.
REQ-024 clear SHALL have priority over commit and moves: next edge occ_x=occ_o=0, turn=0, cursor=0, accept/reject/out_en=0.
REQ-025 Back-to-back commits on consecutive cycles SHALL each be evaluated against occupancy updated by the previous one.
REQ-026 cursor_idx SHALL always be < CELLS.

Reset
REQ-027 Asserting rst SHALL immediately force cursor_idx=0, occ_x=0, occ_o=0, turn=0, accept=0, reject=0, out_en=0.
REQ-028 rst mid-game SHALL discard any commit in flight; no accept/reject pulse SHALL appear after reset release for a pre-reset commit.

Configuration
REQ-029 Macro POSITION_SEL_WRAP_EN SHALL select edge behaviour of the cursor.
REQ-030 With POSITION_SEL_WRAP_EN defined, a move past an edge SHALL wrap to the opposite edge of the same row/column (col BOARD_N-1 + right -> col 0).
REQ-031 Without POSITION_SEL_WRAP_EN, a move past an edge SHALL saturate (cursor unchanged).

Verification
REQ-032 Reset, BOARD_N=3, enable=1, commit at idx 0 -> next cycle accept=1, out_en=9'b000000001, occ_x=9'b000000001, turn=1.
REQ-033 Commit again at idx 0 -> next cycle reject=1, accept=0, out_en=0, occ_o=0, turn stays 1.
REQ-034 From idx 2, mv_right -> WRAP_EN defined: cursor_idx=0; undefined: cursor_idx=2; mv_up+mv_left together -> no move.
REQ-035 Nine legal commits at idx 0..8 -> occ_x=9'b101010101, occ_o=9'b010101010, full=1; tenth commit -> reject=1.
REQ-036 commit with enable=0 -> no accept/reject, cursor_oh=0; clear asserted same cycle as commit -> occupancy 0, turn=0, no accept.
REQ-037 BOARD_N=4, cursor at idx 15, commit -> out_en=16'h8000; rst asserted between commit edge and pulse cycle -> accept stays 0.
